// File: rtl/shift_frame_pkg.sv
// Shared types for the serial frame receiver: FSM state encoding and the
// bit-counter width helper.
package shift_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } rx_state_e;

    // Counter must hold the value WIDTH itself, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_directional_reg.sv
// Bidirectional serial-in shift register with synchronous clear; a clear and a
// shift in the same cycle leave only the new bit in an otherwise empty register.
module shift_directional_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             direction,
    input  logic             data_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] base;

    // direction=1 moves bits toward bit 0 with the new bit at the MSB.
    always_comb begin
        base = clear ? '0 : q_q;
        q_d  = base;
        if (shift_en) begin
            if (direction) begin
                q_d = {data_in, base[WIDTH-1:1]};
            end else begin
                q_d = {base[WIDTH-2:0], data_in};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_frame_rx_ctrl.sv
// Serial frame receiver: assembles WIDTH bits into a held output word with
// overrun tracking. Optional trailing even-parity bit via SHIFT_FRAME_RX_PARITY_EN.
module shift_frame_rx_ctrl
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lsb_first,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

    // Output handshake: word_out is valid while word_valid is high and is
    // consumed on any edge where word_valid and word_ready are both high.
    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] sr;
    logic             frame_full;
    logic             shift_en;
    logic             dir_eff;
    logic             load_word;
    logic             drop_word;

`ifdef SHIFT_FRAME_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic par_seen_q, par_seen_d;
    logic perr_q, perr_d;
`endif

    assign frame_full = (cnt_q == CNT_FULL);
    assign dir_eff    = start ? lsb_first : dir_q;
    assign shift_en   = bit_valid && (start || (state_q == ST_RECV && !frame_full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start is honoured in every state and always restarts the frame.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RECV;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RECV: begin
                    if (frame_full) begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                ST_PARITY: begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
                    if (par_seen_q) begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        load_word = 1'b0;
        drop_word = 1'b0;
        if (state_q == ST_DONE) begin
            load_word = !word_valid_q || word_ready;
            drop_word = !load_word;
        end
    end

    shift_directional_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .shift_en (shift_en),
        .direction(dir_eff),
        .data_in  (bit_in),
        .q        (sr)
    );

    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        overrun_d    = overrun_q;
        if (start) begin
            cnt_d = bit_valid ? CW'(1) : '0;
            dir_d = lsb_first;
        end else if (shift_en) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (load_word) begin
            word_d       = sr;
            word_valid_d = 1'b1;
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
        if (drop_word) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SHIFT_FRAME_RX_PARITY_EN
    // The parity bit is latched first, then the next cycle moves to DONE.
    always_comb begin
        par_bit_d  = par_bit_q;
        par_seen_d = 1'b0;
        perr_d     = perr_q;
        if (!start && state_q == ST_PARITY && !par_seen_q && bit_valid) begin
            par_seen_d = 1'b1;
            par_bit_d  = bit_in;
        end
        if (load_word) begin
            perr_d = (^sr) ^ par_bit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q  <= 1'b0;
            par_seen_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            par_bit_q  <= par_bit_d;
            par_seen_q <= par_seen_d;
            perr_q     <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_frame_rx_ctrl.sv
// Directed and randomized checks of shift_frame_rx_ctrl against a
// transaction-level model of frames, delivery and overrun.
module tb_shift_frame_rx_ctrl;

    localparam int W = 8;
`ifdef SHIFT_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, lsb_first, bit_valid, bit_in, word_ready, clr_overrun;
    logic [W-1:0] word_out;
    logic         word_valid, parity_err, overrun, busy;

    int total = 0;
    int bad   = 0;

    // drive controls
    logic     g_lsb = 1'b0;
    int       g_rdy_mode = 0;
    logic     g_clr = 1'b0;
    logic     g_par = 1'b0;

    // reference model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_word, m_acc;
    logic         m_valid, m_perr, m_ovr, m_active, m_dir, m_par, m_parwait;
    int           m_cnt, m_due, m_skip;
    int           rises;
    logic         prev_wv;

    always #5 clk = ~clk;

    shift_frame_rx_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lsb_first  (lsb_first),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word = '0; m_acc = '0; m_valid = 0; m_perr = 0; m_ovr = 0;
        m_active = 0; m_dir = 0; m_par = 0; m_parwait = 0;
        m_cnt = 0; m_due = 0; m_skip = 0; prev_wv = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"}, 32'(word_out), 32'h0);
        chk({tag, "_valid"}, 32'(word_valid), 32'h0);
        chk({tag, "_perr"}, 32'(parity_err), 32'h0);
        chk({tag, "_ovr"}, 32'(overrun), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // One clock: drive, advance the model by one edge, then compare.
    task automatic step(input logic st, input logic bv, input logic bi);
        logic         rdy, deliver, set_ovr;
        logic [W-1:0] w;
        rdy = (g_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (g_rdy_mode == 1);
        start       = st;
        lsb_first   = st ? g_lsb : 1'($urandom_range(0, 1));
        bit_valid   = bv;
        bit_in      = bi;
        word_ready  = rdy;
        clr_overrun = g_clr;
        @(posedge clk);
        deliver = (m_due == 1);
        set_ovr = 1'b0;
        if (deliver) begin
            w = exp_q.pop_front();
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1'b1;
                m_perr  = PAR ? ((^w) ^ m_par) : 1'b0;
            end else begin
                set_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (g_clr) m_ovr = 1'b0;
        if (st) begin
            m_active = 1'b1; m_cnt = 0; m_acc = '0; m_dir = g_lsb;
            m_due = 0; m_parwait = 1'b0; exp_q.delete();
        end else begin
            if (m_due > 0) m_due--;
            if (deliver) m_active = 1'b0;
            if (m_parwait) begin
                if (m_skip > 0) m_skip--;
                else if (bv) begin
                    m_par = bi; m_parwait = 1'b0; m_due = 2;
                end
            end
        end
        if (bv && m_active && m_cnt < W) begin
            if (m_dir) m_acc[m_cnt] = bi;
            else m_acc[W-1-m_cnt] = bi;
            m_cnt++;
            if (m_cnt == W) begin
                exp_q.push_back(m_acc);
                if (PAR) begin
                    m_parwait = 1'b1; m_skip = 1;
                end else begin
                    m_due = 2;
                end
            end
        end
        #1;
        chk("word_out", 32'(word_out), 32'(m_word));
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(m_active));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
        if (word_valid === 1'b1 && prev_wv === 1'b0) rises++;
        prev_wv = word_valid;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // seq[0] is transmitted first.
    task automatic send_seq(input logic [W-1:0] seq, input logic lsb, input logic sbit, input logic gaps);
        g_lsb = lsb;
        if (sbit) begin
            step(1'b1, 1'b1, seq[0]);
        end else begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, seq[0]);
        end
        for (int i = 1; i < W; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(1'b0, 1'b1, seq[i]);
        end
`ifdef SHIFT_FRAME_RX_PARITY_EN
        step(1'b0, 1'b0, 1'b0);
        if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, g_par);
`endif
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic lsb, input logic sbit, input logic gaps);
        logic [W-1:0] seq;
        for (int i = 0; i < W; i++) seq[i] = lsb ? w[i] : w[W-1-i];
        send_seq(seq, lsb, sbit, gaps);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        start = 0; bit_valid = 0; bit_in = 0; word_ready = 0; clr_overrun = 0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; lsb_first = 0; bit_valid = 0; bit_in = 0; word_ready = 0; clr_overrun = 0;
        model_reset();
        rises = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // bit order and delivery latency
        g_rdy_mode = 0;
        send_seq(8'b0000_0101, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_early", 32'(word_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_on", 32'(word_valid), 32'h1);
        chk("lsb_word", 32'(word_out), 32'h05);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;
        send_seq(8'b0000_0101, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("msb_word", 32'(word_out), 32'hA0);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;

        // overrun
        send_frame(8'h11, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        idle(3);
        send_frame(8'h22, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        idle(3);
        chk("ovr_word", 32'(word_out), 32'h11);
        chk("ovr_set", 32'(overrun), 32'h1);
        g_clr = 1; idle(1); g_clr = 0;
        chk("ovr_clr", 32'(overrun), 32'h0);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;

        // completion on the same edge the held word is accepted
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        idle(3);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        idle(1);
        g_rdy_mode = 1; idle(1);
        chk("b2b_valid", 32'(word_valid), 32'h1);
        chk("b2b_word", 32'(word_out), 32'hC3);
        chk("b2b_ovr", 32'(overrun), 32'h0);
        idle(1); g_rdy_mode = 0;

        // abort mid-frame
        rises = 0;
        g_lsb = 1'b1;
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("abort_word", 32'(word_out), 32'hFF);
        idle(3);
        chk("abort_rises", 32'(rises), 32'h1);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;

        // reset mid-frame
        g_lsb = 1'b0;
        step(1'b1, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
        do_reset();
        idle(4);
        chk("post_rst_valid", 32'(word_valid), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("post_rst_word", 32'(word_out), 32'h3C);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;

`ifdef SHIFT_FRAME_RX_PARITY_EN
        g_par = 1'b1;
        send_seq(8'b0000_0101, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("perr_one", 32'(parity_err), 32'h1);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;
        g_par = 1'b0;
        send_seq(8'b0000_0101, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("perr_zero", 32'(parity_err), 32'h0);
        g_rdy_mode = 1; idle(1); g_rdy_mode = 0;
`endif

        // randomized frames with random consumer, aborts and idle noise
        g_rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            g_par = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                g_lsb = 1'($urandom_range(0, 1));
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 5)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            send_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            idle(3);
            repeat ($urandom_range(0, 3)) begin
                g_clr = ($urandom_range(0, 3) == 0);
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            g_clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
